// File: rtl/branch_resolve_ctrl_if.sv
// Branch resolution bus: ID push side, EX resolve side, predictor update,
// fetch recovery and optional performance counters.
// master = pipeline/predictor side, slave = branch_resolve_ctrl.
interface branch_resolve_ctrl_if #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
);
    logic             id_br_valid;
    logic             id_prdt_br;
    logic [PC_W-1:0]  id_alt_pc;
    logic             id_ready;
    logic             ex_br_valid;
    logic             ex_br_taken;
    logic             ex_ready;
    logic             prdt_work;
    logic             prdt_branch;
    logic             prdt_cancel;
    logic             flush;
    logic [PC_W-1:0]  redirect_pc;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] mis_cnt;

    modport master (
        output id_br_valid, id_prdt_br, id_alt_pc, ex_br_valid, ex_br_taken,
        input  id_ready, ex_ready, prdt_work, prdt_branch, prdt_cancel,
               flush, redirect_pc, br_cnt, mis_cnt
    );

    modport slave (
        input  id_br_valid, id_prdt_br, id_alt_pc, ex_br_valid, ex_br_taken,
        output id_ready, ex_ready, prdt_work, prdt_branch, prdt_cancel,
               flush, redirect_pc, br_cnt, mis_cnt
    );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: in-flight branch FIFO between ID and EX.
// Each EX resolution is matched against the oldest predicted branch; a
// registered one-cycle predictor update follows every pop, and a mispredict
// clears the FIFO, flushes the pipe and redirects fetch to the alternate PC.
// Optional feature macro: BR_PERF_CNT_EN (resolved / mispredicted counters).
module branch_resolve_ctrl #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    branch_resolve_ctrl_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [AW:0]     r_wr_ptr;
    logic [AW:0]     r_rd_ptr;
    logic            r_prdt_q [DEPTH];
    logic [PC_W-1:0] r_alt_q  [DEPTH];

    logic            r_prdt_work;
    logic            r_prdt_cancel;
    logic            r_flush;
    logic [PC_W-1:0] r_redirect_pc;

    logic            w_run;
    logic            w_full;
    logic            w_empty;
    logic            w_id_ready;
    logic            w_ex_ready;
    logic            w_push;
    logic            w_pop;
    logic            w_mis;
    logic            w_head_prdt;
    logic [PC_W-1:0] w_head_alt;

    // Extra MSB on the pointers separates full (MSBs differ) from empty.
    assign w_run       = (r_state == ST_RUN);
    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                         (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_id_ready  = ~w_full & w_run;
    assign w_ex_ready  = ~w_empty & w_run;
    assign w_push      = bus.id_br_valid & w_id_ready;
    assign w_pop       = bus.ex_br_valid & w_ex_ready;
    assign w_head_prdt = r_prdt_q[r_rd_ptr[AW-1:0]];
    assign w_head_alt  = r_alt_q[r_rd_ptr[AW-1:0]];
    assign w_mis       = w_pop & (bus.ex_br_taken != w_head_prdt);

    assign bus.id_ready    = w_id_ready;
    assign bus.ex_ready    = w_ex_ready;
    assign bus.prdt_work   = r_prdt_work;
    assign bus.prdt_branch = r_prdt_work;
    assign bus.prdt_cancel = r_prdt_cancel;
    assign bus.flush       = r_flush;
    assign bus.redirect_pc = r_redirect_pc;

    // Recovery sequencing: RUN -> FLUSH on mispredict -> RECOVER -> RUN.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_mis) begin
                    w_state_nxt = ST_FLUSH;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_FLUSH:   w_state_nxt = ST_RECOVER;
            ST_RECOVER: w_state_nxt = ST_RUN;
            default:    w_state_nxt = ST_RUN;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FIFO pointers; a mispredict discards every entry including a same-cycle push.
    always_ff @(posedge clk) begin
        if (rst || w_mis) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    // FIFO storage: {predicted direction, alternate PC} per entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_prdt_q[i] <= 1'b0;
                r_alt_q[i]  <= '0;
            end
        end else if (w_push && !w_mis) begin
            r_prdt_q[r_wr_ptr[AW-1:0]] <= bus.id_prdt_br;
            r_alt_q[r_wr_ptr[AW-1:0]]  <= bus.id_alt_pc;
        end
    end

    // Registered predictor update strobe, one cycle after each pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prdt_work   <= 1'b0;
            r_prdt_cancel <= 1'b0;
        end else begin
            r_prdt_work   <= w_pop;
            r_prdt_cancel <= w_pop & ~bus.ex_br_taken;
        end
    end

    // Flush pulse for the FLUSH cycle; redirect PC holds between mispredicts.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flush       <= 1'b0;
            r_redirect_pc <= '0;
        end else begin
            r_flush <= w_mis;
            if (w_mis) begin
                r_redirect_pc <= w_head_alt;
            end
        end
    end

`ifdef BR_PERF_CNT_EN
    logic [CNT_W-1:0] r_br_cnt;
    logic [CNT_W-1:0] r_mis_cnt;

    // Performance counters: resolved and mispredicted branches, free-wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_br_cnt  <= '0;
            r_mis_cnt <= '0;
        end else begin
            if (w_pop) begin
                r_br_cnt <= r_br_cnt + CNT_W'(1);
            end
            if (w_mis) begin
                r_mis_cnt <= r_mis_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.br_cnt  = r_br_cnt;
    assign bus.mis_cnt = r_mis_cnt;
`else
    assign bus.br_cnt  = {CNT_W{1'b0}};
    assign bus.mis_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl. A behavioural queue model
// produces one expected record per driven cycle; each test pops it and
// compares after the clock edge.
module tb_branch_resolve_ctrl;
    localparam int DEPTH = 4;

    logic clk;
    logic rst;

    branch_resolve_ctrl_if #(.PC_W(32), .CNT_W(32)) bus ();

    branch_resolve_ctrl #(.DEPTH(DEPTH), .PC_W(32), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          prdt;
        logic [31:0] alt;
    } ent_t;

    typedef struct {
        bit   [5:0]  flags;  // {id_ready, ex_ready, work, branch, cancel, flush}
        logic [31:0] redir;
        logic [31:0] brc;
        logic [31:0] misc;
    } exp_t;

    typedef struct {
        bit          idv;
        bit          prdt;
        logic [31:0] alt;
        bit          exv;
        bit          tk;
    } stim_t;

    ent_t        mq[$];
    exp_t        exp_q[$];
    int          mstate;   // 0 RUN, 1 FLUSH, 2 RECOVER
    logic [31:0] m_redir;
    logic [31:0] m_br;
    logic [31:0] m_mis;
    bit   [1:0]  obs_rdy;

    int n_pass  = 0;
    int n_total = 0;

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        mstate  = 0;
        m_redir = 32'h0;
        m_br    = 32'h0;
        m_mis   = 32'h0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.id_br_valid = 1'b0;
        bus.id_prdt_br  = 1'b0;
        bus.id_alt_pc   = 32'h0;
        bus.ex_br_valid = 1'b0;
        bus.ex_br_taken = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Drive one cycle, advance the model, queue the expected post-edge view.
    task automatic step(input stim_t s);
        exp_t e;
        ent_t h;
        bit   pop, push, mis, mrun;
        bus.id_br_valid = s.idv;
        bus.id_prdt_br  = s.prdt;
        bus.id_alt_pc   = s.alt;
        bus.ex_br_valid = s.exv;
        bus.ex_br_taken = s.tk;
        obs_rdy = {bus.id_ready, bus.ex_ready};
        mrun = (mstate == 0);
        e.flags[5] = (mq.size() < DEPTH) && mrun;
        e.flags[4] = (mq.size() != 0) && mrun;
        push = s.idv && e.flags[5];
        pop  = s.exv && e.flags[4];
        mis  = 1'b0;
        if (pop) begin
            h   = mq.pop_front();
            mis = (s.tk != h.prdt);
            m_br = m_br + 32'd1;
            if (mis) begin
                m_mis   = m_mis + 32'd1;
                m_redir = h.alt;
            end
        end
        if (mis) begin
            mq.delete();
        end else if (push) begin
            h.prdt = s.prdt;
            h.alt  = s.alt;
            mq.push_back(h);
        end
        case (mstate)
            0:       mstate = mis ? 1 : 0;
            1:       mstate = 2;
            default: mstate = 0;
        endcase
        e.flags[3] = pop;
        e.flags[2] = pop;
        e.flags[1] = pop && !s.tk;
        e.flags[0] = mis;
        e.redir    = m_redir;
`ifdef BR_PERF_CNT_EN
        e.brc  = m_br;
        e.misc = m_mis;
`else
        e.brc  = 32'h0;
        e.misc = 32'h0;
`endif
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        bus.id_br_valid = 1'b0;
        bus.ex_br_valid = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_total++;
        if ({bus.id_ready, bus.ex_ready, bus.flush, bus.prdt_work} !== 4'b1000) begin
            $display("FAIL reset_ctrl: got {id_rdy,ex_rdy,flush,work}=%b expected 1000",
                     {bus.id_ready, bus.ex_ready, bus.flush, bus.prdt_work});
        end else n_pass++;
        n_total++;
        if ({bus.br_cnt, bus.mis_cnt, bus.redirect_pc} !== 96'h0) begin
            $display("FAIL reset_regs: got br=%0d mis=%0d redir=%h expected 0 0 0",
                     bus.br_cnt, bus.mis_cnt, bus.redirect_pc);
        end else n_pass++;
    endtask

    task automatic test_correct();
        stim_t s[$];
        exp_t  e;
        s.push_back('{1'b1, 1'b1, 32'h100, 1'b0, 1'b0});
        s.push_back('{1'b0, 1'b0, 32'h0,   1'b1, 1'b1});
        s.push_back('{1'b0, 1'b0, 32'h0,   1'b0, 1'b0});
        foreach (s[i]) begin
            step(s[i]);
            e = exp_q.pop_front();
            n_total++;
            if ({obs_rdy, bus.prdt_work, bus.prdt_branch, bus.prdt_cancel, bus.flush} !== e.flags) begin
                $display("FAIL correct_flags[%0d]: got %b expected %b", i,
                         {obs_rdy, bus.prdt_work, bus.prdt_branch, bus.prdt_cancel, bus.flush}, e.flags);
            end else n_pass++;
            n_total++;
            if ({bus.redirect_pc, bus.br_cnt, bus.mis_cnt} !== {e.redir, e.brc, e.misc}) begin
                $display("FAIL correct_regs[%0d]: got redir=%h br=%0d mis=%0d expected %h %0d %0d", i,
                         bus.redirect_pc, bus.br_cnt, bus.mis_cnt, e.redir, e.brc, e.misc);
            end else n_pass++;
        end
    endtask

    task automatic test_mispredict();
        stim_t s[$];
        exp_t  e;
        s.push_back('{1'b1, 1'b1, 32'h200, 1'b0, 1'b0});
        s.push_back('{1'b1, 1'b0, 32'h300, 1'b0, 1'b0});
        s.push_back('{1'b0, 1'b0, 32'h0,   1'b1, 1'b0});  // resolves not-taken
        s.push_back('{1'b1, 1'b1, 32'h900, 1'b1, 1'b1});  // FLUSH: both blocked
        s.push_back('{1'b1, 1'b1, 32'h900, 1'b1, 1'b1});  // RECOVER: both blocked
        s.push_back('{1'b0, 1'b0, 32'h0,   1'b1, 1'b0});  // RUN, empty: no strobe
        foreach (s[i]) begin
            step(s[i]);
            e = exp_q.pop_front();
            n_total++;
            if ({obs_rdy, bus.prdt_work, bus.prdt_branch, bus.prdt_cancel, bus.flush} !== e.flags) begin
                $display("FAIL mispredict_flags[%0d]: got %b expected %b", i,
                         {obs_rdy, bus.prdt_work, bus.prdt_branch, bus.prdt_cancel, bus.flush}, e.flags);
            end else n_pass++;
            n_total++;
            if ({bus.redirect_pc, bus.br_cnt, bus.mis_cnt} !== {e.redir, e.brc, e.misc}) begin
                $display("FAIL mispredict_regs[%0d]: got redir=%h br=%0d mis=%0d expected %h %0d %0d", i,
                         bus.redirect_pc, bus.br_cnt, bus.mis_cnt, e.redir, e.brc, e.misc);
            end else n_pass++;
            if (i == 2) begin
                n_total++;
                if ({bus.flush, bus.redirect_pc, bus.prdt_cancel} !== {1'b1, 32'h200, 1'b1}) begin
                    $display("FAIL mispredict_redirect: got flush=%b pc=%h cancel=%b expected 1 00000200 1",
                             bus.flush, bus.redirect_pc, bus.prdt_cancel);
                end else n_pass++;
            end
        end
    endtask

    task automatic test_full();
        stim_t s[$];
        exp_t  e;
        for (int k = 0; k < 4; k++) s.push_back('{1'b1, 1'b1, 32'h400 + 32'(k), 1'b0, 1'b0});
        s.push_back('{1'b1, 1'b1, 32'h404, 1'b0, 1'b0});  // full: waits
        s.push_back('{1'b1, 1'b1, 32'h404, 1'b1, 1'b1});  // pop, push still blocked
        s.push_back('{1'b1, 1'b1, 32'h404, 1'b0, 1'b0});  // accepted now
        for (int k = 0; k < 4; k++) s.push_back('{1'b0, 1'b0, 32'h0, 1'b1, 1'b1});
        s.push_back('{1'b0, 1'b0, 32'h0, 1'b0, 1'b0});
        foreach (s[i]) begin
            step(s[i]);
            e = exp_q.pop_front();
            n_total++;
            if ({obs_rdy, bus.prdt_work, bus.prdt_branch, bus.prdt_cancel, bus.flush} !== e.flags) begin
                $display("FAIL full_flags[%0d]: got %b expected %b", i,
                         {obs_rdy, bus.prdt_work, bus.prdt_branch, bus.prdt_cancel, bus.flush}, e.flags);
            end else n_pass++;
            if (i == 4 || i == 5) begin
                n_total++;
                if (obs_rdy[1] !== 1'b0) begin
                    $display("FAIL full_block[%0d]: got id_ready=%b expected 0", i, obs_rdy[1]);
                end else n_pass++;
            end
        end
    endtask

    task automatic test_simultaneous();
        stim_t s[$];
        exp_t  e;
        s.push_back('{1'b1, 1'b0, 32'h440, 1'b0, 1'b0});
        s.push_back('{1'b1, 1'b1, 32'h550, 1'b1, 1'b1});  // mispredict + push
        s.push_back('{1'b0, 1'b0, 32'h0,   1'b1, 1'b1});
        s.push_back('{1'b0, 1'b0, 32'h0,   1'b1, 1'b1});
        s.push_back('{1'b0, 1'b0, 32'h0,   1'b1, 1'b1});  // RUN, empty
        s.push_back('{1'b0, 1'b0, 32'h0,   1'b0, 1'b0});
        foreach (s[i]) begin
            step(s[i]);
            e = exp_q.pop_front();
            n_total++;
            if ({obs_rdy, bus.prdt_work, bus.prdt_branch, bus.prdt_cancel, bus.flush} !== e.flags) begin
                $display("FAIL simul_flags[%0d]: got %b expected %b", i,
                         {obs_rdy, bus.prdt_work, bus.prdt_branch, bus.prdt_cancel, bus.flush}, e.flags);
            end else n_pass++;
            n_total++;
            if (bus.redirect_pc !== e.redir) begin
                $display("FAIL simul_redir[%0d]: got %h expected %h", i, bus.redirect_pc, e.redir);
            end else n_pass++;
        end
        n_total++;
        if (bus.ex_ready !== 1'b0) begin
            $display("FAIL simul_empty: got ex_ready=%b expected 0", bus.ex_ready);
        end else n_pass++;
    endtask

    task automatic test_reset_mid();
        stim_t s;
        exp_t  e;
        s = '{1'b1, 1'b1, 32'hA0, 1'b0, 1'b0};
        step(s);
        s = '{1'b1, 1'b0, 32'hB0, 1'b0, 1'b0};
        step(s);
        apply_reset();
        s = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0};
        step(s);
        e = exp_q.pop_front();
        n_total++;
        if ({obs_rdy, bus.prdt_work, bus.prdt_branch, bus.prdt_cancel, bus.flush} !== e.flags) begin
            $display("FAIL reset_mid_flags: got %b expected %b",
                     {obs_rdy, bus.prdt_work, bus.prdt_branch, bus.prdt_cancel, bus.flush}, e.flags);
        end else n_pass++;
    endtask

    task automatic test_back_to_back_wrap();
        stim_t s[$];
        exp_t  e;
        apply_reset();
        s.push_back('{1'b1, 1'b0, 32'h1000, 1'b0, 1'b0});
        for (int k = 1; k < 10; k++) begin
            s.push_back('{1'b1, k[0], 32'h1000 + 32'(k), 1'b1, ~k[0]});
        end
        s.push_back('{1'b0, 1'b0, 32'h0, 1'b1, 1'b1});
        s.push_back('{1'b0, 1'b0, 32'h0, 1'b0, 1'b0});
        foreach (s[i]) begin
            step(s[i]);
            e = exp_q.pop_front();
            n_total++;
            if ({obs_rdy, bus.prdt_work, bus.prdt_branch, bus.prdt_cancel, bus.flush} !== e.flags) begin
                $display("FAIL wrap_flags[%0d]: got %b expected %b", i,
                         {obs_rdy, bus.prdt_work, bus.prdt_branch, bus.prdt_cancel, bus.flush}, e.flags);
            end else n_pass++;
            n_total++;
            if ({bus.br_cnt, bus.mis_cnt} !== {e.brc, e.misc}) begin
                $display("FAIL wrap_cnt[%0d]: got br=%0d mis=%0d expected %0d %0d", i,
                         bus.br_cnt, bus.mis_cnt, e.brc, e.misc);
            end else n_pass++;
        end
        n_total++;
`ifdef BR_PERF_CNT_EN
        if (bus.br_cnt !== 32'd10) begin
            $display("FAIL wrap_total: got br_cnt=%0d expected 10", bus.br_cnt);
        end else n_pass++;
`else
        if (bus.br_cnt !== 32'd0) begin
            $display("FAIL wrap_total: got br_cnt=%0d expected 0", bus.br_cnt);
        end else n_pass++;
`endif
    endtask

    initial begin
        rst = 1'b1;
        model_reset();
        test_reset();
        test_correct();
        test_mispredict();
        test_full();
        test_simultaneous();
        test_reset_mid();
        test_back_to_back_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
